// File: rtl/rf_arbiter.sv
// Sequencer/arbiter in front of a 32x32 register file: post-reset clear, core/debug
// arbitration with a starvation guard, and same-transaction write-to-read bypass.
module rf_arbiter #(
  parameter int unsigned DW          = 32,
  parameter int unsigned AW          = 5,
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned MAX_WAIT    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          core_req,
  input  logic          core_we,
  input  logic [AW-1:0] core_rs_add,
  input  logic [AW-1:0] core_rt_add,
  input  logic [AW-1:0] core_rd_add,
  input  logic [DW-1:0] core_rd_data,
  output logic          core_gnt,
  output logic          core_rvalid,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_rs_add,
  input  logic [AW-1:0] dbg_rt_add,
  input  logic [AW-1:0] dbg_rd_add,
  input  logic [DW-1:0] dbg_rd_data,
  output logic          dbg_gnt,
  output logic          dbg_rvalid,
  output logic [DW-1:0] rs_data,
  output logic [DW-1:0] rt_data,
  output logic          ready,
  output logic          rf_rst,
  output logic          rf_we,
  output logic [AW-1:0] rf_rs_add,
  output logic [AW-1:0] rf_rt_add,
  output logic [AW-1:0] rf_rd_add,
  output logic [DW-1:0] rf_rd_data,
  input  logic [DW-1:0] rf_rs_data,
  input  logic [DW-1:0] rf_rt_data
);

  localparam int unsigned ICW = $clog2(INIT_CYCLES + 1);
  localparam int unsigned WCW = $clog2(MAX_WAIT + 1);
  localparam logic [ICW-1:0] INIT_LAST = ICW'(INIT_CYCLES);
  localparam logic [WCW-1:0] WAIT_SAT  = WCW'(MAX_WAIT);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t         state, state_nxt;
  logic [ICW-1:0] init_cnt, init_cnt_nxt;
  logic [WCW-1:0] wait_cnt;
  logic           dbg_forced;
  logic           byp_rs, byp_rt;

  logic           core_pend, dbg_pend;
  logic           byp_rs_q, byp_rt_q;
  logic [DW-1:0]  wdata_q;
  logic [DW-1:0]  rs_hold, rt_hold;
  logic           ret_v;
  logic [DW-1:0]  rs_ret, rt_ret;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // Clear stays asserted until the edge after INIT_CYCLES counted edges.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    rf_rst       = 1'b0;
    ready        = 1'b0;
    case (state)
      ST_INIT: begin
        rf_rst = 1'b1;
        if (init_cnt == INIT_LAST) begin
          state_nxt = ST_RUN;
        end else begin
          init_cnt_nxt = init_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        ready = 1'b1;
      end
      default: begin
        state_nxt = ST_INIT;
      end
    endcase
  end

  always_comb begin
    dbg_forced = ready && dbg_req && (wait_cnt == WAIT_SAT);
    core_gnt   = ready && core_req && !dbg_forced;
    dbg_gnt    = ready && dbg_req && !core_gnt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (ready) begin
      if (!dbg_req || dbg_gnt) begin
        wait_cnt <= '0;
      end else if (wait_cnt != WAIT_SAT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    rf_we      = 1'b0;
    rf_rs_add  = '0;
    rf_rt_add  = '0;
    rf_rd_add  = '0;
    rf_rd_data = '0;
    if (core_gnt) begin
      rf_we      = core_we;
      rf_rs_add  = core_rs_add;
      rf_rt_add  = core_rt_add;
      rf_rd_add  = core_rd_add;
      rf_rd_data = core_rd_data;
    end else if (dbg_gnt) begin
      rf_we      = dbg_we;
      rf_rs_add  = dbg_rs_add;
      rf_rt_add  = dbg_rt_add;
      rf_rd_add  = dbg_rd_add;
      rf_rd_data = dbg_rd_data;
    end
  end

  // The register file returns pre-write data on a same-edge read; r0 is never bypassed.
  always_comb begin
    byp_rs = rf_we && (rf_rd_add != '0) && (rf_rd_add == rf_rs_add);
    byp_rt = rf_we && (rf_rd_add != '0) && (rf_rd_add == rf_rt_add);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_pend <= 1'b0;
      dbg_pend  <= 1'b0;
      byp_rs_q  <= 1'b0;
      byp_rt_q  <= 1'b0;
      wdata_q   <= '0;
      rs_hold   <= '0;
      rt_hold   <= '0;
    end else begin
      core_pend <= core_gnt;
      dbg_pend  <= dbg_gnt;
      byp_rs_q  <= byp_rs;
      byp_rt_q  <= byp_rt;
      wdata_q   <= rf_rd_data;
      if (ret_v) begin
        rs_hold <= rs_ret;
        rt_hold <= rt_ret;
      end
    end
  end

  // Read data arrives combinationally in the return cycle, then is held.
  always_comb begin
    ret_v       = core_pend || dbg_pend;
    rs_ret      = byp_rs_q ? wdata_q : rf_rs_data;
    rt_ret      = byp_rt_q ? wdata_q : rf_rt_data;
    rs_data     = ret_v ? rs_ret : rs_hold;
    rt_data     = ret_v ? rt_ret : rt_hold;
    core_rvalid = core_pend;
    dbg_rvalid  = dbg_pend;
  end

endmodule

// File: tb/tb_rf_arbiter.sv
// Self-checking bench for rf_arbiter: directed scenarios plus randomized traffic
// compared against an array-based register/arbitration model.
module tb_rf_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int MAXW = 4;

  logic          clk, rst;
  logic          core_req, core_we, core_gnt, core_rvalid;
  logic [AW-1:0] core_rs_add, core_rt_add, core_rd_add;
  logic [DW-1:0] core_rd_data;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] dbg_rs_add, dbg_rt_add, dbg_rd_add;
  logic [DW-1:0] dbg_rd_data;
  logic [DW-1:0] rs_data, rt_data;
  logic          ready, rf_rst, rf_we;
  logic [AW-1:0] rf_rs_add, rf_rt_add, rf_rd_add;
  logic [DW-1:0] rf_rd_data, rf_rs_data, rf_rt_data;

  int checks   = 0;
  int failures = 0;

  rf_arbiter #(.DW(DW), .AW(AW), .INIT_CYCLES(2), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_rs_add(core_rs_add),
    .core_rt_add(core_rt_add), .core_rd_add(core_rd_add), .core_rd_data(core_rd_data),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_rs_add(dbg_rs_add),
    .dbg_rt_add(dbg_rt_add), .dbg_rd_add(dbg_rd_add), .dbg_rd_data(dbg_rd_data),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid),
    .rs_data(rs_data), .rt_data(rt_data), .ready(ready), .rf_rst(rf_rst),
    .rf_we(rf_we), .rf_rs_add(rf_rs_add), .rf_rt_add(rf_rt_add),
    .rf_rd_add(rf_rd_add), .rf_rd_data(rf_rd_data),
    .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file environment: synchronous reads returning pre-write data, r0 fixed at 0.
  logic [DW-1:0] rf_mem [32];
  always @(posedge clk) begin
    if (rf_rst) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= '0;
      rf_rs_data <= '0;
      rf_rt_data <= '0;
    end else begin
      rf_rs_data <= rf_mem[rf_rs_add];
      rf_rt_data <= rf_mem[rf_rt_add];
      if (rf_we && rf_rd_add != '0) rf_mem[rf_rd_add] <= rf_rd_data;
    end
  end

  task automatic drive_core(input logic req, input logic we, input logic [AW-1:0] rs,
                            input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                            input logic [DW-1:0] d);
    core_req = req; core_we = we; core_rs_add = rs; core_rt_add = rt;
    core_rd_add = rd; core_rd_data = d;
  endtask

  task automatic drive_dbg(input logic req, input logic we, input logic [AW-1:0] rs,
                           input logic [AW-1:0] rt, input logic [AW-1:0] rd,
                           input logic [DW-1:0] d);
    dbg_req = req; dbg_we = we; dbg_rs_add = rs; dbg_rt_add = rt;
    dbg_rd_add = rd; dbg_rd_data = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic exp;
    rst = 1'b0;
    drive_core(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    drive_dbg(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rf_rst, ready, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, rf_we} !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=1000000",
               {rf_rst, ready, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, rf_we});
    end
    checks++;
    if (rs_data !== '0 || rt_data !== '0) begin
      failures++;
      $display("FAIL reset_data got=%h/%h exp=0/0", rs_data, rt_data);
    end
    step();
    rst = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp = (e == 3);
      checks++;
      if ({rf_rst, ready, core_gnt} !== {~exp, exp, exp}) begin
        failures++;
        $display("FAIL init_edge%0d rf_rst/ready/core_gnt got=%b exp=%b", e,
                 {rf_rst, ready, core_gnt}, {~exp, exp, exp});
      end
    end
    step();
    drive_core(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    @(negedge clk);
    checks++;
    if (core_rvalid !== 1'b1 || rs_data !== '0) begin
      failures++;
      $display("FAIL first_return got=%b/%h exp=1/0", core_rvalid, rs_data);
    end
    step();
  endtask

  task automatic test_write_read();
    drive_core(1'b1, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF);
    @(negedge clk);
    checks++;
    if ({core_gnt, rf_we} !== 2'b11 || rf_rd_add !== 5'd5 || rf_rd_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL wr_drive got=%b%b %0d %h exp=11 5 deadbeef", core_gnt, rf_we, rf_rd_add, rf_rd_data);
    end
    step();
    drive_core(1'b1, 1'b0, 5'd5, 5'd0, 5'd0, '0);
    @(negedge clk);
    checks++;
    if ({core_gnt, core_rvalid, rf_we} !== 3'b110) begin
      failures++;
      $display("FAIL rd_issue got=%b exp=110", {core_gnt, core_rvalid, rf_we});
    end
    step();
    drive_core(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    @(negedge clk);
    checks++;
    if ({core_rvalid, dbg_rvalid} !== 2'b10 || rs_data !== 32'hDEADBEEF || rt_data !== '0) begin
      failures++;
      $display("FAIL rd_return got=%b %h %h exp=10 deadbeef 0", {core_rvalid, dbg_rvalid}, rs_data, rt_data);
    end
    step();
    @(negedge clk);
    checks++;
    if (core_rvalid !== 1'b0 || rs_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL rd_hold got=%b %h exp=0 deadbeef", core_rvalid, rs_data);
    end
    step();
  endtask

  task automatic test_bypass();
    drive_core(1'b1, 1'b1, 5'd0, 5'd0, 5'd3, 32'h55);
    @(negedge clk);
    step();
    drive_core(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    drive_dbg(1'b1, 1'b1, 5'd7, 5'd3, 5'd7, 32'h12345678);
    @(negedge clk);
    checks++;
    if ({core_gnt, dbg_gnt, core_rvalid} !== 3'b011) begin
      failures++;
      $display("FAIL byp_dbg_gnt got=%b exp=011", {core_gnt, dbg_gnt, core_rvalid});
    end
    step();
    drive_dbg(1'b1, 1'b1, 5'd0, 5'd7, 5'd0, 32'hABCD0123);
    @(negedge clk);
    checks++;
    if (dbg_rvalid !== 1'b1 || rs_data !== 32'h12345678 || rt_data !== 32'h55) begin
      failures++;
      $display("FAIL byp_rs got=%b %h %h exp=1 12345678 00000055", dbg_rvalid, rs_data, rt_data);
    end
    step();
    drive_dbg(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    @(negedge clk);
    checks++;
    if (dbg_rvalid !== 1'b1 || rs_data !== '0 || rt_data !== 32'h12345678) begin
      failures++;
      $display("FAIL byp_r0 got=%b %h %h exp=1 0 12345678", dbg_rvalid, rs_data, rt_data);
    end
    step();
    drive_core(1'b1, 1'b1, 5'd3, 5'd9, 5'd9, 32'hCAFEF00D);
    @(negedge clk);
    step();
    drive_core(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    @(negedge clk);
    checks++;
    if (core_rvalid !== 1'b1 || rs_data !== 32'h55 || rt_data !== 32'hCAFEF00D) begin
      failures++;
      $display("FAIL byp_rt got=%b %h %h exp=1 00000055 cafef00d", core_rvalid, rs_data, rt_data);
    end
    step();
  endtask

  task automatic test_idle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if ({core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, rf_we} !== 5'b0 ||
          rs_data !== 32'h55 || rt_data !== 32'hCAFEF00D) begin
        failures++;
        $display("FAIL idle_c%0d got=%b %h %h exp=00000 00000055 cafef00d", c,
                 {core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, rf_we}, rs_data, rt_data);
      end
      step();
    end
  endtask

  task automatic test_priority();
    logic exp_d;
    drive_core(1'b1, 1'b0, 5'd1, 5'd2, 5'd0, '0);
    drive_dbg(1'b1, 1'b0, 5'd3, 5'd4, 5'd0, '0);
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      exp_d = (c == 5);
      checks++;
      if ({core_gnt, dbg_gnt} !== {~exp_d, exp_d}) begin
        failures++;
        $display("FAIL prio_c%0d got=%b exp=%b", c, {core_gnt, dbg_gnt}, {~exp_d, exp_d});
      end
      if (c == 6) begin
        checks++;
        if ({core_rvalid, dbg_rvalid} !== 2'b01 || rs_data !== 32'h55 || rt_data !== '0) begin
          failures++;
          $display("FAIL prio_dbg_ret got=%b %h %h exp=01 00000055 0",
                   {core_rvalid, dbg_rvalid}, rs_data, rt_data);
        end
      end
      step();
    end
    drive_core(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    drive_dbg(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    @(negedge clk);
    step();
  endtask

  task automatic test_random();
    logic [DW-1:0] model [32];
    logic          c_act, d_act, exp_c, exp_d, prev_c, prev_d;
    logic          w_we;
    logic [AW-1:0] c_rs, c_rt, c_rd, d_rs, d_rt, d_rd, w_rs, w_rt, w_rd;
    logic [DW-1:0] c_dat, d_dat, w_dat, prev_rs, prev_rt, last_rs, last_rt;
    logic          c_we, d_we;
    logic          got_ready;
    int            stall;
    for (int i = 0; i < 32; i++) model[i] = '0;
    c_act = 0; d_act = 0; prev_c = 0; prev_d = 0; stall = 0;
    c_we = 0; d_we = 0; c_rs = 0; c_rt = 0; c_rd = 0; c_dat = 0;
    d_rs = 0; d_rt = 0; d_rd = 0; d_dat = 0;
    prev_rs = 0; prev_rt = 0; last_rs = 0; last_rt = 0;
    rst = 1'b0;
    drive_core(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    drive_dbg(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    step(); step();
    rst = 1'b1;
    got_ready = 1'b0;
    for (int k = 0; k < 10 && !got_ready; k++) begin
      @(negedge clk);
      got_ready = ready;
    end
    checks++;
    if (!got_ready) begin
      failures++;
      $display("FAIL rand_ready_timeout got=0 exp=1");
    end
    step();
    for (int n = 0; n < 600; n++) begin
      if (!c_act && $urandom_range(0, 3) != 0) begin
        c_act = 1; c_we = 1'($urandom_range(0, 1));
        c_rs = AW'($urandom_range(0, 7)); c_rt = AW'($urandom_range(0, 7));
        c_rd = AW'($urandom_range(0, 7)); c_dat = $urandom;
      end
      if (!d_act && $urandom_range(0, 2) != 0) begin
        d_act = 1; d_we = 1'($urandom_range(0, 1));
        d_rs = AW'($urandom_range(0, 7)); d_rt = AW'($urandom_range(0, 7));
        d_rd = AW'($urandom_range(0, 7)); d_dat = $urandom;
      end
      drive_core(c_act, c_we, c_rs, c_rt, c_rd, c_dat);
      drive_dbg(d_act, d_we, d_rs, d_rt, d_rd, d_dat);
      @(negedge clk);
      exp_c = c_act && !(d_act && stall >= MAXW);
      exp_d = d_act && !exp_c;
      w_we = 0; w_rs = 0; w_rt = 0; w_rd = 0; w_dat = 0;
      if (exp_c) begin
        w_we = c_we; w_rs = c_rs; w_rt = c_rt; w_rd = c_rd; w_dat = c_dat;
      end else if (exp_d) begin
        w_we = d_we; w_rs = d_rs; w_rt = d_rt; w_rd = d_rd; w_dat = d_dat;
      end
      checks++;
      if ({core_gnt, dbg_gnt, rf_we} !== {exp_c, exp_d, w_we}) begin
        failures++;
        $display("FAIL rand_gnt n=%0d got=%b exp=%b", n, {core_gnt, dbg_gnt, rf_we}, {exp_c, exp_d, w_we});
      end
      if (prev_c || prev_d) begin
        last_rs = prev_rs;
        last_rt = prev_rt;
      end
      checks++;
      if ({core_rvalid, dbg_rvalid} !== {prev_c, prev_d} || rs_data !== last_rs || rt_data !== last_rt) begin
        failures++;
        $display("FAIL rand_ret n=%0d got=%b %h %h exp=%b %h %h", n, {core_rvalid, dbg_rvalid},
                 rs_data, rt_data, {prev_c, prev_d}, last_rs, last_rt);
      end
      prev_rs = (w_we && w_rd != 0 && w_rd == w_rs) ? w_dat : model[w_rs];
      prev_rt = (w_we && w_rd != 0 && w_rd == w_rt) ? w_dat : model[w_rt];
      if ((exp_c || exp_d) && w_we && w_rd != 0) model[w_rd] = w_dat;
      prev_c = exp_c;
      prev_d = exp_d;
      stall = (d_act && !exp_d) ? stall + 1 : 0;
      if (exp_c) c_act = 0;
      if (exp_d) d_act = 0;
      step();
    end
    drive_core(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    drive_dbg(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    @(negedge clk);
    step();
  endtask

  task automatic test_reset_mid();
    logic exp;
    drive_core(1'b1, 1'b1, 5'd1, 5'd1, 5'd1, 32'hA5A5A5A5);
    @(negedge clk);
    step();
    drive_core(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    drive_dbg(1'b1, 1'b0, 5'd1, 5'd1, 5'd0, '0);
    @(negedge clk);
    checks++;
    if ({dbg_gnt, core_rvalid} !== 2'b11 || rs_data !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL mid_pre got=%b %h exp=11 a5a5a5a5", {dbg_gnt, core_rvalid}, rs_data);
    end
    step();
    rst = 1'b0;
    drive_dbg(1'b1, 1'b0, 5'd2, 5'd2, 5'd0, '0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if ({rf_rst, ready, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, rf_we} !== 7'b1000000 ||
          rs_data !== '0 || rt_data !== '0) begin
        failures++;
        $display("FAIL mid_reset_c%0d got=%b %h %h exp=1000000 0 0", c,
                 {rf_rst, ready, core_gnt, dbg_gnt, core_rvalid, dbg_rvalid, rf_we}, rs_data, rt_data);
      end
      step();
    end
    rst = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      @(posedge clk);
      @(negedge clk);
      exp = (e == 3);
      checks++;
      if ({rf_rst, ready, dbg_gnt, dbg_rvalid} !== {~exp, exp, exp, 1'b0}) begin
        failures++;
        $display("FAIL mid_init_edge%0d got=%b exp=%b", e,
                 {rf_rst, ready, dbg_gnt, dbg_rvalid}, {~exp, exp, exp, 1'b0});
      end
    end
    step();
    drive_dbg(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0);
    @(negedge clk);
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_idle();
    test_priority();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_arbiter.md
Name: rf_arbiter

Overview:
Sequencer and arbiter in front of the 32x32 register file: 1 write port, 2 synchronous read ports with 1-cycle read latency, active-high clear, r0 hardwired by the register file. It shares the register file between the multicycle core control (core) and a debug/scan port (dbg), using fixed core priority plus a starvation guard. It sequences the post-reset clear and adds same-transaction write-to-read bypass.

Parameters:
DW, 32, data width
AW, 5, register address width
INIT_CYCLES, 2, cycles rf_rst is held after reset release (>=1)
MAX_WAIT, 4, consecutive stalled dbg cycles before dbg gets forced priority (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
core_req  in  1  core transaction request, held until core_gnt
core_we  in  1  core write enable for the transaction
core_rs_add, core_rt_add, core_rd_add  in  AW each  core read/write addresses
core_rd_data  in  DW  core write data
core_gnt  out  1  core transaction accepted this cycle
core_rvalid  out  1  rs_data/rt_data valid for core
dbg_req, dbg_we, dbg_rs_add, dbg_rt_add, dbg_rd_add, dbg_rd_data  in  1/1/AW/AW/AW/DW  debug equivalents
dbg_gnt  out  1  debug transaction accepted this cycle
dbg_rvalid  out  1  rs_data/rt_data valid for dbg
rs_data, rt_data  out  DW each  shared read-return buses, qualified by *_rvalid
ready  out  1  initialisation done, arbitration active
rf_rst  out  1  active-high clear to register file
rf_we  out  1  register file write enable
rf_rs_add, rf_rt_add, rf_rd_add  out  AW each  register file addresses
rf_rd_data  out  DW  register file write data
rf_rs_data, rf_rt_data  in  DW each  register file read data (1-cycle latency)

Behaviour:
- rst=0 (async): state INIT, init counter=0, wait counter=0, rf_rst=1, ready=0, all gnt/rvalid=0, rs_data/rt_data=0, rf_we=0. Pending read returns are discarded, never delivered.
- FSM INIT: rf_rst=1 for INIT_CYCLES rising edges after rst goes high, then RUN. No grants in INIT; requests are ignored and stay pending.
- FSM RUN: ready=1, rf_rst=0. RUN is left only via rst.
- Arbitration is combinational in the request cycle; at most one grant per cycle.
  - Default: core_req wins.
  - If wait counter == MAX_WAIT and dbg_req=1, dbg wins over core.
  - Loser sees gnt=0 and must hold req and all fields stable.
- Wait counter: +1 (saturating at MAX_WAIT) each RUN cycle with dbg_req=1 and dbg_gnt=0; cleared on dbg_gnt or dbg_req=0.
- Granted requester's addresses and write data drive rf_* combinationally. rf_we = gnt & that requester's we. With no grant: rf_we=0, addresses 0.
- Read return: every grant is also a read of rs/rt. Winner's *_rvalid=1 exactly one cycle after its gnt, for one cycle. rs_data/rt_data hold their last value otherwise.
- Bypass: the register file returns pre-write contents for a same-edge read. If the granted transaction has we=1, rd_add!=0 and rd_add==rs_add (resp. rt_add), the returned rs_data (resp. rt_data) is the transaction's write data, not rf_rs_data.
- No bypass when rd_add==0; the r0 read returns the register file value, i.e. 0.
- Back-to-back grants (any mix of requesters) are legal every cycle. A read in cycle N+1 after a write in cycle N needs no bypass.
- core_gnt and dbg_gnt are never both 1. core_rvalid and dbg_rvalid are never both 1.

Test Plan:
- Reset: hold rst=0 3 cycles, then release -> rf_rst=1 for exactly 2 edges, ready rises on the 3rd edge, no gnt while core_req=1 during INIT.
- Core write then read: core writes r5=0xDEADBEEF (gnt cycle N), reads rs=r5 in N+1 -> core_rvalid in N+2 with rs_data=0xDEADBEEF.
- Priority: core_req and dbg_req both held -> core_gnt 4 cycles, dbg_gnt in the 5th cycle (MAX_WAIT=4), wait counter back to 0, core_gnt again next cycle.
- Bypass: single transaction we=1, rd=r7, data=0x12345678, rs=r7, rt=r3 (r3=0x55) -> next cycle rs_data=0x12345678, rt_data=0x55. Same with rd=r0, rs=r0 -> rs_data=0.
- Reset mid-operation: drop rst the cycle after a dbg_gnt -> dbg_rvalid never asserts, all outputs at reset values, INIT re-entered.
- Idle: no requests for 10 cycles in RUN -> rf_we=0, no rvalid, rs_data/rt_data unchanged.
